// File: rtl/uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio
//
// Memory-mapped console transmitter that answers on the core's data-memory
// store port, next to dmem. Stores to TX_ADDR are buffered in a FIFO and
// serialised as 8N1 frames, LSB first, on tx. STAT_ADDR reads back the FIFO
// level, the sticky overflow flag, busy, full and empty. The core's read mux
// selects DOUT over dmem data whenever hit is high.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of 2, >= 2)
//   TX_ADDR       word address of the TX data register
//   STAT_ADDR     word address of the status register
//
// Ports
//   clock   in   1   system clock, rising edge
//   clear   in   1   synchronous active-low reset
//   ADDR    in   8   word address from the MEM stage
//   DIN     in   32  store data; DIN[7:0] is the TX byte, DIN[3] clears overflow
//   wren    in   1   store strobe
//   func3   in   3   store width (unused: any store to TX_ADDR pushes a byte)
//   DOUT    out  32  registered read data, valid the cycle after ADDR
//   hit     out  1   ADDR decodes to one of this block's registers
//   tx      out  1   serial line, idles high, driven from a flop
//   busy    out  1   frame in progress or FIFO not empty
//
// Status word: {24'b0, level[3:0], overflow, busy, full, empty}
// -----------------------------------------------------------------------------
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [7:0]  TX_ADDR      = 8'hFF,
  parameter logic [7:0]  STAT_ADDR    = 8'hFE
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  ADDR,
  input  logic [31:0] DIN,
  input  logic        wren,
  input  logic [2:0]  func3,
  output logic [31:0] DOUT,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          r_overflow;
  logic [7:0]    r_last_byte;
  logic [31:0]   r_dout;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic          r_tx;

  // Next-state values for the serialiser
  logic [1:0]    w_state_d;
  logic [CW-1:0] w_cnt_d;
  logic [2:0]    w_bit_d;
  logic [7:0]    w_shreg_d;
  logic          w_tx_d;

  // ---------------------------------------------------------------------------
  // Decode and FIFO flags
  // ---------------------------------------------------------------------------
  logic          w_sel_tx;
  logic          w_sel_stat;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_clr;
  logic          w_empty;
  logic          w_full;
  logic          w_busy;
  logic          w_bit_end;
  logic [AW:0]   w_level;
  logic [31:0]   w_level32;
  logic [3:0]    w_level_sat;
  logic [7:0]    w_head;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // func3 and the upper store data never influence this block
  assign w_unused = ^{func3, DIN[31:8]};

  assign w_sel_tx   = (ADDR == TX_ADDR);
  assign w_sel_stat = (ADDR == STAT_ADDR);
  assign hit        = w_sel_tx | w_sel_stat;

  assign w_empty = (r_rp == r_wp);
  assign w_full  = (r_rp[AW] != r_wp[AW]) && (r_rp[AW-1:0] == r_wp[AW-1:0]);
  assign w_level = r_wp - r_rp;
  assign w_head  = r_mem[r_rp[AW-1:0]];

  assign w_level32   = 32'(w_level);
  assign w_level_sat = (w_level32 > 32'd15) ? 4'hF : w_level32[3:0];

  assign w_bit_end = (r_cnt == '0);
  assign w_busy    = (r_state != ST_IDLE) || !w_empty;

  // The serialiser pops from IDLE, or at the end of a stop bit to chain frames
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  // A pop on the same edge frees the slot, so a store into a full FIFO still lands
  assign w_push_req = wren && w_sel_tx;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_clr  = wren && w_sel_stat && DIN[3];

  // ---------------------------------------------------------------------------
  // Read mux (registered into DOUT)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = 32'h0;
    if (w_sel_tx) begin
      w_rdata = {24'h0, r_last_byte};
    end else if (w_sel_stat) begin
      w_rdata = {24'h0, w_level_sat, r_overflow, w_busy, w_full, w_empty};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: no reset needed, validity is tracked by the pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (clear && w_push) begin
      r_mem[r_wp[AW-1:0]] <= DIN[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, status and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_overflow  <= 1'b0;
      r_last_byte <= 8'h00;
      r_dout      <= 32'h0;
    end else begin
      if (w_push) begin
        r_wp        <= r_wp + PTR_ONE;
        r_last_byte <= DIN[7:0];
      end
      if (w_pop) begin
        r_rp <= r_rp + PTR_ONE;
      end
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
      r_dout <= w_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser next state. tx is computed one edge ahead so it comes from a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bit_d   = r_bit;
    w_shreg_d = r_shreg;
    w_tx_d    = r_tx;

    case (r_state)
      ST_IDLE: begin
        w_tx_d = 1'b1;
        if (!w_empty) begin
          w_shreg_d = w_head;
          w_state_d = ST_START;
          w_cnt_d   = CNT_LOAD;
          w_tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_d = ST_DATA;
          w_cnt_d   = CNT_LOAD;
          w_bit_d   = 3'd0;
          w_tx_d    = r_shreg[0];
        end else begin
          w_cnt_d = r_cnt - CNT_ONE;
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_d   = CNT_LOAD;
          w_shreg_d = {1'b0, r_shreg[7:1]};
          if (r_bit == 3'd7) begin
            w_state_d = ST_STOP;
            w_tx_d    = 1'b1;
          end else begin
            w_bit_d = r_bit + 3'd1;
            // Next data bit is the one about to shift into position 0
            w_tx_d  = r_shreg[1];
          end
        end else begin
          w_cnt_d = r_cnt - CNT_ONE;
        end
      end

      ST_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            // Back-to-back frame: no idle gap
            w_shreg_d = w_head;
            w_state_d = ST_START;
            w_cnt_d   = CNT_LOAD;
            w_tx_d    = 1'b0;
          end else begin
            w_state_d = ST_IDLE;
            w_cnt_d   = CNT_LOAD;
            w_tx_d    = 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt - CNT_ONE;
        end
      end

      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = CNT_LOAD;
        w_tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_LOAD;
      r_bit   <= 3'd0;
      r_shreg <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bit   <= w_bit_d;
      r_shreg <= w_shreg_d;
      r_tx    <= w_tx_d;
    end
  end

  assign tx   = r_tx;
  assign busy = w_busy;
  assign DOUT = r_dout;

endmodule
